// File: rtl/fifo_rd_stream.sv
// Read-side drain stage behind the sync FIFO. It prefetches words into a small
// ring buffer and presents them to the consumer as a valid/ready stream.
module fifo_rd_stream #(
    parameter  int DATA_W    = 8,
    parameter  int BUF_DEPTH = 3,
    localparam int LVL_W     = $clog2(BUF_DEPTH + 1),
    localparam int PTR_W     = $clog2(BUF_DEPTH)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_flush,
    output logic              o_rden,
    input  logic [DATA_W-1:0] i_rddata,
    input  logic              i_empty,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [LVL_W-1:0]  o_level
);

    logic [BUF_DEPTH-1:0][DATA_W-1:0] mem_q;
    logic [LVL_W-1:0]                 cnt;
    logic [PTR_W-1:0]                 rd_ptr, wr_ptr;
    logic                             inflight;
    logic [LVL_W:0]                   occ;
    logic                             push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Issue only looks at registered state and i_empty, so m_ready never
    // reaches the FIFO read enable combinationally.
    always_comb begin
        occ    = {1'b0, cnt} + (LVL_W + 1)'(inflight);
        o_rden = rstn && !i_empty && !i_flush && (occ < (LVL_W + 1)'(BUF_DEPTH));
    end

    assign m_valid = (cnt != '0);
    assign m_data  = mem_q[rd_ptr];
    assign o_level = cnt;
    assign push    = inflight;
    assign pop     = m_valid && m_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_q    <= '0;
            cnt      <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= o_rden;
            if (i_flush) begin
                // The returning word (if any) is simply not written.
                cnt    <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) begin
                    mem_q[wr_ptr] <= i_rddata;
                    wr_ptr        <= ptr_inc(wr_ptr);
                end
                if (pop)
                    rd_ptr <= ptr_inc(rd_ptr);
                case ({push, pop})
                    2'b10:   cnt <= cnt + LVL_W'(1);
                    2'b01:   cnt <= cnt - LVL_W'(1);
                    default: cnt <= cnt;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: FIFO model with 1-clk read latency, a directed
// vector table, hand sequences for corner cases and a random scoreboard run.
module tb_fifo_rd_stream;

    logic       clk = 1'b0;
    logic       rstn;
    logic       i_flush;
    logic       o_rden;
    logic [7:0] i_rddata;
    logic       i_empty;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic [1:0] o_level;

    fifo_rd_stream #(.DATA_W(8), .BUF_DEPTH(3)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .i_flush  (i_flush),
        .o_rden   (o_rden),
        .i_rddata (i_rddata),
        .i_empty  (i_empty),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .o_level  (o_level)
    );

    always #5 clk = ~clk;

    // Source FIFO: registered read data, empty reflects all earlier reads.
    logic [7:0] mem [0:1023];
    int head = 0;
    int tail = 0;
    assign i_empty = (head == tail);
    always @(posedge clk) begin
        if (o_rden) begin
            i_rddata <= mem[head % 1024];
            head     <= head + 1;
        end
    end

    logic [7:0] exp_q [$];
    int  n_chk = 0, n_pass = 0;
    int  issued = 0, delivered = 0;
    bit  last_rden = 1'b0, stall_prev = 1'b0;
    logic [7:0] held = '0;

    typedef struct {
        bit         push;
        logic [7:0] wdata;
        bit         rdy;
        bit         flush;
        bit         e_rden;
        bit         e_valid;
        logic [7:0] e_data;
        int         e_lvl;
    } vec_t;
    vec_t vecs [14];

    task automatic chk(input string name, input bit ok, input int act, input int exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic push_word(input logic [7:0] d);
        mem[tail % 1024] = d;
        tail = tail + 1;
        exp_q.push_back(d);
    endtask

    // One clock: inputs already driven after a negedge; check, account, advance.
    task automatic tick();
        int exp_lvl;
        logic [7:0] e;
        #1;
        exp_lvl = rstn ? (issued - delivered - int'(last_rden)) : 0;
        chk("no_underflow", !(o_rden && i_empty), int'(o_rden), 0);
        chk("level_model", int'(o_level) == exp_lvl, int'(o_level), exp_lvl);
        chk("valid_model", m_valid == (exp_lvl != 0), int'(m_valid), int'(exp_lvl != 0));
        if (stall_prev)
            chk("hold_stable", m_valid && (m_data == held), int'(m_data), int'(held));
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_word", 1'b0, int'(m_data), -1);
            end else begin
                e = exp_q.pop_front();
                chk("order_data", m_data == e, int'(m_data), int'(e));
            end
            delivered++;
        end
        stall_prev = rstn && !i_flush && m_valid && !m_ready;
        held       = m_data;
        if (o_rden) issued++;
        if (i_flush || !rstn) begin
            for (int k = 0; k < issued - delivered; k++)
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            delivered = issued;
        end
        last_rden = o_rden;
        @(negedge clk);
    endtask

    initial begin
        int d0;
        logic [7:0] v;
        // push wdata rdy flush | rden valid data lvl
        vecs[0]  = '{1, 8'h10, 1, 0, 1, 0, 8'h00, 0};
        vecs[1]  = '{1, 8'h11, 0, 0, 1, 0, 8'h00, 0};
        vecs[2]  = '{1, 8'h12, 0, 0, 1, 1, 8'h10, 1};
        vecs[3]  = '{1, 8'h13, 0, 0, 0, 1, 8'h10, 2};
        vecs[4]  = '{0, 8'h00, 0, 0, 0, 1, 8'h10, 3};
        vecs[5]  = '{0, 8'h00, 1, 0, 0, 1, 8'h10, 3};
        vecs[6]  = '{0, 8'h00, 1, 0, 1, 1, 8'h11, 2};
        vecs[7]  = '{0, 8'h00, 0, 0, 0, 1, 8'h12, 1};
        vecs[8]  = '{1, 8'h14, 0, 0, 1, 1, 8'h12, 2};
        vecs[9]  = '{0, 8'h00, 0, 1, 0, 1, 8'h12, 2};
        vecs[10] = '{1, 8'h15, 1, 0, 1, 0, 8'h00, 0};
        vecs[11] = '{0, 8'h00, 1, 0, 0, 0, 8'h00, 0};
        vecs[12] = '{0, 8'h00, 1, 0, 0, 1, 8'h15, 1};
        vecs[13] = '{0, 8'h00, 1, 0, 0, 0, 8'h00, 0};

        rstn = 1'b0; i_flush = 1'b0; m_ready = 1'b1;
        push_word(8'hA5);
        @(negedge clk);

        // Reset with a non-empty FIFO and a ready consumer.
        repeat (3) begin
            #1;
            chk("rst_rden", o_rden == 1'b0, int'(o_rden), 0);
            chk("rst_valid", m_valid == 1'b0, int'(m_valid), 0);
            chk("rst_level", o_level == 2'd0, int'(o_level), 0);
            tick();
        end
        rstn = 1'b1;
        #1 chk("rel_rden", o_rden == 1'b1, int'(o_rden), 1);
        tick();
        tick();
        #1 chk("first_word", m_valid && m_data == 8'hA5, int'(m_data), 8'hA5);
        tick();
        tick();

        // Directed vectors: latency, saturation, hold, flush with a word in flight.
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].push) push_word(vecs[i].wdata);
            m_ready = vecs[i].rdy;
            i_flush = vecs[i].flush;
            #1;
            chk($sformatf("vec%0d_rden", i), o_rden == vecs[i].e_rden, int'(o_rden), int'(vecs[i].e_rden));
            chk($sformatf("vec%0d_valid", i), m_valid == vecs[i].e_valid, int'(m_valid), int'(vecs[i].e_valid));
            chk($sformatf("vec%0d_level", i), int'(o_level) == vecs[i].e_lvl, int'(o_level), vecs[i].e_lvl);
            if (vecs[i].e_valid)
                chk($sformatf("vec%0d_data", i), m_data == vecs[i].e_data, int'(m_data), int'(vecs[i].e_data));
            tick();
        end
        i_flush = 1'b0;

        // Streaming: 16 preloaded words drain at one per clock after 2 clk.
        for (int i = 0; i < 16; i++) push_word(8'(i));
        m_ready = 1'b1;
        d0 = delivered;
        repeat (18) tick();
        chk("stream_rate", delivered - d0 == 16, delivered - d0, 16);

        // Backpressure: level saturates at depth and reads stop.
        for (int i = 0; i < 20; i++) push_word(8'h40 + 8'(i));
        repeat (5) tick();
        m_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 9) begin
                #1;
                chk("bp_level", o_level == 2'd3, int'(o_level), 3);
                chk("bp_rden", o_rden == 1'b0, int'(o_rden), 0);
            end
            tick();
        end
        m_ready = 1'b1;
        repeat (25) tick();

        // Sparse source: one word every 4 clk.
        for (int i = 0; i < 4; i++) begin
            v = 8'h80 + 8'(i * 3);
            push_word(v);
            #1 chk("sparse_rden", o_rden == 1'b1, int'(o_rden), 1);
            tick();
            tick();
            #1 chk("sparse_word", m_valid && m_data == v, int'(m_data), int'(v));
            tick();
            #1 chk("sparse_gap", m_valid == 1'b0, int'(m_valid), 0);
            tick();
            tick();
        end

        // Random traffic with flushes.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(1, 0) == 1 && (tail - head) < 512)
                push_word(8'($urandom));
            m_ready = ($urandom_range(9, 0) < 7);
            i_flush = ($urandom_range(49, 0) == 0);
            tick();
        end
        i_flush = 1'b0;
        m_ready = 1'b1;
        repeat (600) begin
            if (head == tail && exp_q.size() == 0 && !m_valid) break;
            tick();
        end
        chk("drain_scoreboard", exp_q.size() == 0, exp_q.size(), 0);
        chk("drain_fifo", head == tail, tail - head, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
